// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM encodings and parameter defaults for the data-memory responder.
package dm_pkg;
    localparam int DM_AW_DEF   = 8;
    localparam int DM_WAIT_DEF = 1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;
endpackage

// File: rtl/dm_ram.sv
// dm_ram: 2**AW x 16 array, one synchronous write port and one asynchronous read port.
module dm_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [15:0]   i_wd,
    input  logic [AW-1:0] i_ra,
    output logic [15:0]   o_rd
);
    logic [15:0] r_mem [2**AW];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_wa] <= i_wd;
    assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/dm_resp.sv
// dm_resp: data-memory responder with a posted one-entry write buffer,
// DM_WAIT read wait states and out-of-range address detection.
module dm_resp
    import dm_pkg::*;
#(
    parameter int DM_AW   = DM_AW_DEF,
    parameter int DM_WAIT = DM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps_dm_en,
    input  logic        ps_dm_wrt_en,
    input  logic [15:0] dg_dm_add,
    input  logic [15:0] bc_dt,
    output logic [15:0] dm_bc_dt,
    output logic        dm_rd_vld,
    output logic        dm_ps_stall,
    output logic        dm_err
);
    localparam logic [1:0] WAIT_LAST = 2'(DM_WAIT - 1);

    dm_state_e        r_state, w_nxt;
    logic [1:0]       r_cnt;
    logic             r_wb_vld, r_rd_oor, r_err;
    logic [DM_AW-1:0] r_wb_add, r_rd_add, w_rd_add;
    logic [15:0]      r_wb_dt, r_dt, w_ram_dt, w_rd_dt;
    logic             w_acc, w_oor, w_rd, w_wr, w_rd_oor;

    assign w_oor    = (dg_dm_add >> DM_AW) != 16'd0;
    assign w_acc    = ps_dm_en & ~dm_ps_stall;
    assign w_rd     = w_acc & ~ps_dm_wrt_en;
    assign w_wr     = w_acc & ps_dm_wrt_en & ~w_oor;
    // With DM_WAIT=0 RESP is entered on the accept edge, so use the live address.
    assign w_rd_add = (r_state == ST_WAIT) ? r_rd_add : dg_dm_add[DM_AW-1:0];
    assign w_rd_oor = (r_state == ST_WAIT) ? r_rd_oor : w_oor;
    assign w_rd_dt  = w_rd_oor ? 16'h0000 :
                      (r_wb_vld && r_wb_add == w_rd_add) ? r_wb_dt : w_ram_dt;

    dm_ram #(.AW(DM_AW)) u_ram (
        .clk  (clk),
        .i_we (r_wb_vld),
        .i_wa (r_wb_add),
        .i_wd (r_wb_dt),
        .i_ra (w_rd_add),
        .o_rd (w_ram_dt)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (r_state == ST_WAIT) ? r_cnt + 2'd1 : 2'd0;
        end

    always_comb begin
        w_nxt = r_state;
        if (r_state == ST_WAIT) w_nxt = (r_cnt == WAIT_LAST) ? ST_RESP : ST_WAIT;
        else                    w_nxt = !w_rd ? ST_IDLE : (DM_WAIT > 0) ? ST_WAIT : ST_RESP;
    end

    always_comb begin
        dm_ps_stall = r_state == ST_WAIT;
        dm_rd_vld   = r_state == ST_RESP;
        dm_err      = r_err;
        dm_bc_dt    = r_dt;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wb_vld <= 1'b0;
            r_wb_add <= '0;
            r_wb_dt  <= '0;
            r_rd_add <= '0;
            r_rd_oor <= 1'b0;
            r_dt     <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wb_vld <= w_wr;
            r_err    <= w_acc & w_oor;
            if (w_wr) begin
                r_wb_add <= dg_dm_add[DM_AW-1:0];
                r_wb_dt  <= bc_dt;
            end
            if (w_rd) begin
                r_rd_add <= dg_dm_add[DM_AW-1:0];
                r_rd_oor <= w_oor;
            end
            if (w_nxt == ST_RESP) r_dt <= w_rd_dt;
        end
endmodule
